// File: rtl/dsp_pkg.sv
// Shared DSP types and defaults: trigger FSM states, default sample geometry and
// the lane-index width helper used by the slope trigger.
package dsp_pkg;

  localparam int unsigned DefaultSampleWidth     = 16;
  localparam int unsigned DefaultParallelSamples = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLDOFF,
    REARM
  } trigger_state_t;

  // A single-lane bus still carries a 1-bit lane index.
  function automatic int unsigned lane_idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/axis_slope_trigger_if.sv
// AXI-Stream style valid/ready/data bundle with master and slave views.
interface Axis_If #(
  parameter int unsigned DATA_WIDTH = dsp_pkg::DefaultSampleWidth * dsp_pkg::DefaultParallelSamples
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lane_priority_encoder.sv
// Reduces a per-lane hit vector to an any-hit flag and the lowest hitting lane index.
module lane_priority_encoder
  import dsp_pkg::*;
#(
  parameter int unsigned Lanes    = DefaultParallelSamples,
  parameter int unsigned IdxWidth = lane_idx_width(Lanes)
) (
  input  logic [Lanes-1:0]    hits_i,
  output logic                any_o,
  output logic [IdxWidth-1:0] idx_o
);

  always_comb begin
    any_o = |hits_i;
    idx_o = '0;
    // Walk downwards so the earliest (lowest) lane wins.
    for (int i = int'(Lanes) - 1; i >= 0; i--) begin
      if (hits_i[i]) idx_o = IdxWidth'(i);
    end
  end

endmodule

// File: rtl/axis_slope_trigger.sv
// Hysteresis/holdoff trigger on a differentiated sample stream, one-beat pass-through.
// Define AXIS_SLOPE_TRIGGER_COUNT_EN to implement the saturating trigger_count.
module axis_slope_trigger
  import dsp_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH     = DefaultSampleWidth,
  parameter int unsigned PARALLEL_SAMPLES = DefaultParallelSamples,
  parameter int unsigned HOLDOFF_WIDTH    = 16,
  localparam int unsigned LaneWidth       = lane_idx_width(PARALLEL_SAMPLES)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  Axis_If.slave                    data_in,
  Axis_If.master                   data_out,
  input  logic                     enable,
  input  logic [SAMPLE_WIDTH-1:0]  thresh_high,
  input  logic [SAMPLE_WIDTH-1:0]  thresh_low,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  output logic                     trigger,
  output logic [LaneWidth-1:0]     trigger_lane,
  output logic [31:0]              trigger_count
);

  localparam int unsigned DataWidth = SAMPLE_WIDTH * PARALLEL_SAMPLES;

  trigger_state_t             state_q, state_d;
  logic [HOLDOFF_WIDTH-1:0]   hcnt_q, hcnt_d;
  logic                       out_valid_q;
  logic [DataWidth-1:0]       out_data_q;
  logic                       trig_q;
  logic [LaneWidth-1:0]       lane_q;
  logic                       accept;
  logic                       fire;
  logic [PARALLEL_SAMPLES-1:0] above_high;
  logic [PARALLEL_SAMPLES-1:0] below_low;
  logic                       any_hit;
  logic [LaneWidth-1:0]       hit_lane;

  assign data_in.ready  = data_out.ready || !out_valid_q;
  assign accept         = data_in.valid && data_in.ready;
  assign data_out.valid = out_valid_q;
  assign data_out.data  = out_data_q;
  assign trigger        = trig_q;
  assign trigger_lane   = lane_q;

  always_comb begin
    above_high = '0;
    below_low  = '0;
    for (int i = 0; i < int'(PARALLEL_SAMPLES); i++) begin
      above_high[i] = $signed(data_in.data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > $signed(thresh_high);
      below_low[i]  = $signed(data_in.data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) < $signed(thresh_low);
    end
  end

  lane_priority_encoder #(
    .Lanes    (PARALLEL_SAMPLES),
    .IdxWidth (LaneWidth)
  ) u_lane_enc (
    .hits_i (above_high),
    .any_o  (any_hit),
    .idx_o  (hit_lane)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    fire    = 1'b0;
    if (accept) begin
      if (!enable) begin
        state_d = IDLE;
        hcnt_d  = '0;
      end else begin
        case (state_q)
          IDLE:  state_d = REARM;
          ARMED: begin
            if (any_hit) begin
              fire    = 1'b1;
              hcnt_d  = holdoff;
              state_d = (holdoff == '0) ? REARM : HOLDOFF;
            end
          end
          HOLDOFF: begin
            if (hcnt_q <= HOLDOFF_WIDTH'(1)) begin
              hcnt_d  = '0;
              state_d = REARM;
            end else begin
              hcnt_d = hcnt_q - HOLDOFF_WIDTH'(1);
            end
          end
          REARM: if (&below_low) state_d = ARMED;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Trigger flags travel in the same register slot as the beat they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      trig_q      <= 1'b0;
      lane_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data_in.data;
      trig_q      <= fire;
      lane_q      <= fire ? hit_lane : '0;
    end else if (data_out.ready) begin
      out_valid_q <= 1'b0;
      trig_q      <= 1'b0;
      lane_q      <= '0;
    end
  end

`ifdef AXIS_SLOPE_TRIGGER_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (fire && (count_q != '1)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign trigger_count = count_q;
`else
  assign trigger_count = '0;
`endif

endmodule

// File: tb/tb_axis_slope_trigger.sv
// Self-checking bench: directed vectors with literal expectations plus a randomized
// handshake run checked every cycle against a rule-level reference model.
module tb_axis_slope_trigger;

  localparam int unsigned SW = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] thresh_high = 16'd100;
  logic [15:0] thresh_low = 16'd10;
  logic [15:0] holdoff = 16'd3;
  logic        trigger;
  logic [0:0]  trigger_lane;
  logic [31:0] trigger_count;

  int vectors = 0;
  int miscompares = 0;

  Axis_If #(.DATA_WIDTH(32)) in_if ();
  Axis_If #(.DATA_WIDTH(32)) out_if ();

  axis_slope_trigger dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (in_if),
    .data_out      (out_if),
    .enable        (enable),
    .thresh_high   (thresh_high),
    .thresh_low    (thresh_low),
    .holdoff       (holdoff),
    .trigger       (trigger),
    .trigger_lane  (trigger_lane),
    .trigger_count (trigger_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain rule-following over accepted beats.
  logic        m_valid, m_trig;
  logic [31:0] m_data;
  int          m_lane;
  longint      m_count;
  bit          m_active, m_armed;
  int          m_hold_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 0; m_data <= 0; m_trig <= 0; m_lane <= 0; m_count <= 0;
      m_active <= 0; m_armed <= 0; m_hold_left <= 0;
    end else begin
      bit acc, f, act, arm, all_low;
      int hl, ln;
      shortint s [2];
      acc = in_if.valid && (out_if.ready || !m_valid);
      if (acc) begin
        s[0] = shortint'(in_if.data[15:0]);
        s[1] = shortint'(in_if.data[31:16]);
        f = 0; ln = 0; act = m_active; arm = m_armed; hl = m_hold_left;
        if (!enable) begin
          act = 0; arm = 0; hl = 0;
        end else if (!act) begin
          act = 1; arm = 0;
        end else if (hl > 0) begin
          hl--;
        end else if (!arm) begin
          all_low = (s[0] < shortint'(thresh_low)) && (s[1] < shortint'(thresh_low));
          if (all_low) arm = 1;
        end else begin
          for (int i = 1; i >= 0; i--) if (s[i] > shortint'(thresh_high)) begin f = 1; ln = i; end
          if (f) begin arm = 0; hl = int'(holdoff); end
        end
        m_active <= act; m_armed <= arm; m_hold_left <= hl;
        m_valid <= 1; m_data <= in_if.data; m_trig <= f; m_lane <= ln;
        if (f && m_count < 64'hFFFF_FFFF) m_count <= m_count + 1;
      end else if (out_if.ready) begin
        m_valid <= 0; m_trig <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_if.ready, out_if.ready || !m_valid);
    chk("out_valid", out_if.valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_if.data, m_data);
      chk("trigger", trigger, m_trig);
      if (m_trig) chk("trigger_lane", trigger_lane, m_lane[0]);
    end
`ifdef AXIS_SLOPE_TRIGGER_COUNT_EN
    chk("trigger_count", trigger_count, m_count[31:0]);
`else
    chk("trigger_count", trigger_count, 0);
`endif
  end

  // Drive one beat from a negedge with out ready high; check at the following negedge.
  task automatic beat(input int a, input int b, input bit et, input int el, input string nm);
    in_if.data  = {16'(b), 16'(a)};
    in_if.valid = 1'b1;
    @(posedge clk);
    #1 in_if.valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, out_if.valid, 1);
    chk({nm, "_trig"}, trigger, et);
    chk({nm, "_model"}, m_trig, et);
    if (et) chk({nm, "_lane"}, trigger_lane, el);
  endtask

  initial begin
    shortint pick [13] = '{-200, -50, 0, 5, 9, 10, 11, 99, 100, 101, 150, 32767, -32768};
    in_if.valid  = 1'b1;
    in_if.data   = 32'h0005_0007;
    out_if.ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_if.valid, 0);
    chk("rst_trig", trigger, 0);
    chk("rst_count", trigger_count, 0);
    chk("rst_data", out_if.data, 0);
    in_if.valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    beat(0, 0, 0, 0, "idle_to_rearm");
    beat(0, 0, 0, 0, "rearm_to_armed");
    beat(50, 150, 1, 1, "basic_fire");
    for (int i = 0; i < 3; i++) beat(200, 200, 0, 0, "holdoff_quiet");
    beat(50, 50, 0, 0, "no_rearm");
    beat(5, -3, 0, 0, "rearm_no_fire");
    beat(101, 0, 1, 0, "fire_lane0");
    for (int i = 0; i < 3; i++) beat(0, 0, 0, 0, "holdoff2");
    beat(0, 0, 0, 0, "rearm2");
    beat(100, 100, 0, 0, "equal_high");
    thresh_high = 16'hFFFF;
    holdoff = 16'd0;
    beat(-32768, 32767, 1, 1, "extremes");
    thresh_high = 16'd100;
    holdoff = 16'd3;
    beat(0, 0, 0, 0, "zero_holdoff_rearm");
    beat(120, 0, 1, 0, "fire_after_h0");
    beat(0, 0, 0, 0, "in_holdoff");
    enable = 1'b0;
    beat(150, 150, 0, 0, "disable");
    enable = 1'b1;
    beat(150, 150, 0, 0, "reenable_idle");
    beat(150, 150, 0, 0, "reenable_rearm");
    beat(0, 0, 0, 0, "reenable_arm");
    beat(150, 150, 1, 0, "reenable_fire");
`ifdef AXIS_SLOPE_TRIGGER_COUNT_EN
    chk("count_directed", trigger_count, 5);
`else
    chk("count_directed", trigger_count, 0);
`endif

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      in_if.valid  = ($urandom_range(0, 2) != 0);
      in_if.data   = {16'(pick[$urandom_range(0, 12)]), 16'(pick[$urandom_range(0, 12)])};
      out_if.ready = ($urandom_range(0, 2) != 0);
      enable       = ($urandom_range(0, 29) != 0);
      holdoff      = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) thresh_high = 16'(pick[$urandom_range(0, 12)]);
    end

    // Reset with a beat stuck under backpressure must drop it.
    @(posedge clk);
    #1;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_if.valid, 0);
    chk("midrst_trig", trigger, 0);
    in_if.valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    out_if.ready = 1'b1;
    enable = 1'b1;
    thresh_high = 16'd100;
    beat(0, 0, 0, 0, "post_rst_rearm");
    beat(0, 0, 0, 0, "post_rst_arm");
    beat(150, 0, 1, 0, "post_rst_fire");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
